ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive equal synchronized samples needed before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT, default 50000: clk cycles without a filtered falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  system clock (25 MHz pixel clock); the block has one clock.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous, idle high.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous, idle high.
REQ-007 up1, down1, left1, right1, fire1  output  1 each  player-1 key held levels (W, S, A, D, Space).
REQ-008 up2, down2, left2, right2, fire2  output  1 each  player-2 key held levels (arrow Up/Down/Left/Right, main Enter).
REQ-009 byte_valid  output  1  one-cycle pulse for each correctly received byte.
REQ-010 rx_byte  output  8  last correctly received byte; holds between pulses.
REQ-011 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer.
REQ-013 Filtered clock SHALL change level only after FILTER_LEN consecutive identical synchronized samples.
REQ-014 Data SHALL be sampled on the cycle a filtered-clock falling edge is detected.
REQ-015 Frame: start(0), 8 data bits LSB first, odd parity, stop(1); 11 falling edges; bit counter 0..10.
REQ-016 Receiver FSM states: IDLE, SHIFT, CHECK. IDLE->SHIFT on a falling edge with data=0. A falling edge with data=1 in IDLE SHALL be ignored. SHIFT->CHECK on the 11th edge. CHECK->IDLE after one cycle.
REQ-017 In CHECK, byte_valid SHALL pulse and rx_byte update when parity is odd and stop=1; otherwise frame_err SHALL pulse and rx_byte hold.
REQ-018 In SHIFT, TIMEOUT cycles with no falling edge SHALL return the FSM to IDLE, clear the bit counter and pulse frame_err.
REQ-019 Decoder state: ext flag, brk flag. On a valid byte:
 - E0 sets ext.
 - F0 sets brk.
 - FA, AA, EE, FE clear both flags; outputs unchanged.
 - 00, FF (overrun) clear both flags and force all ten key outputs to 0.
 - Any other byte: if (ext, code) is mapped, that output SHALL be set to ~brk. Mapped or not, ext and brk SHALL clear.
REQ-020 Scancode map (set 2):
 - Non-extended: W=1D, S=1B, A=1C, D=23, Space=29, Enter=5A.
 - Extended: Up=75, Down=72, Left=6B, Right=74.
 - E0 5A (keypad Enter) and non-extended 75/72/6B/74 (keypad digits) SHALL be unmapped.
REQ-021 Key outputs are registered and SHALL change exactly one cycle after the byte_valid pulse of the final byte of a sequence.
REQ-022 Repeated make codes (typematic) SHALL be idempotent. Keys are independent; any combination may be held simultaneously.
REQ-023 A frame_err SHALL NOT change ext, brk or key outputs.

Reset
REQ-024 While clrn=0, all outputs SHALL be 0, rx_byte 00, FSM IDLE, bit counter 0, ext=brk=0.
REQ-025 Synchronizer and filter registers SHALL reset to 1 (bus idle). clrn asserted mid-frame SHALL discard the partial frame.
REQ-026 After clrn release, the first accepted frame SHALL start at a falling edge seen after release.

Structure
REQ-027 Shared package tankwar_pkg SHALL hold:
 - scancode constants (SC_W, SC_S, SC_A, SC_D, SC_SPACE, SC_ENTER, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_E0, SC_F0);
 - the ignore/overrun codes;
 - the receiver state enum.
REQ-028 Frame reception (REQ-012..018) SHALL be a sub-module ps2_rx. ps2_key_decoder SHALL instantiate it and contain the make/break decoder.

Verification
REQ-029 Bench SHALL drive PS/2 frames at a 40 us bit period.
REQ-030 Send 1D -> byte_valid pulses with rx_byte=1D, up1=1 one cycle later. Then F0 1D -> up1=0. No other output changes.
REQ-031 Send E0 75, then 1D -> up2=1 and up1=1 simultaneously held. Then E0 F0 75 -> up2=0, up1 still 1.
REQ-032 Send 5A -> fire2=1. Send E0 5A -> fire2 unchanged. Send 75 -> no output change, ext clear.
REQ-033 Send a frame of 1D with even parity -> frame_err pulse, up1 stays 0, rx_byte unchanged. Next valid 1C -> left1=1.
REQ-034 Send 4 bits then idle 50000 cycles -> frame_err pulse, FSM IDLE. Following full frame 23 -> right1=1.
REQ-035 Hold 29 and 1B (fire1=down1=1), then send FF -> all outputs 0. Also assert clrn mid-frame -> all outputs 0 and a clean frame after release is decoded.

Source files
------------

// File: rtl/tankwar_pkg.sv
`default_nettype none
// ============================================================================
// Module : tankwar_pkg
// Desc   : Scancodes, key slot indices and receiver state type shared by the
//          PS/2 keyboard front end.
// Rev    : 1.0 - initial release
// ============================================================================
package tankwar_pkg;

    localparam logic [7:0] SC_W       = 8'h1D;
    localparam logic [7:0] SC_S       = 8'h1B;
    localparam logic [7:0] SC_A       = 8'h1C;
    localparam logic [7:0] SC_D       = 8'h23;
    localparam logic [7:0] SC_SPACE   = 8'h29;
    localparam logic [7:0] SC_ENTER   = 8'h5A;
    localparam logic [7:0] SC_UP      = 8'h75;
    localparam logic [7:0] SC_DOWN    = 8'h72;
    localparam logic [7:0] SC_LEFT    = 8'h6B;
    localparam logic [7:0] SC_RIGHT   = 8'h74;
    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_F0      = 8'hF0;

    // Controller replies that carry no key information
    localparam logic [7:0] SC_ACK     = 8'hFA;
    localparam logic [7:0] SC_BAT_OK  = 8'hAA;
    localparam logic [7:0] SC_ECHO    = 8'hEE;
    localparam logic [7:0] SC_RESEND  = 8'hFE;

    // Keyboard buffer overrun markers
    localparam logic [7:0] SC_OVR_00  = 8'h00;
    localparam logic [7:0] SC_OVR_FF  = 8'hFF;

    localparam int NUM_KEYS = 10;

    localparam logic [3:0] KEY_UP1    = 4'd0;
    localparam logic [3:0] KEY_DOWN1  = 4'd1;
    localparam logic [3:0] KEY_LEFT1  = 4'd2;
    localparam logic [3:0] KEY_RIGHT1 = 4'd3;
    localparam logic [3:0] KEY_FIRE1  = 4'd4;
    localparam logic [3:0] KEY_UP2    = 4'd5;
    localparam logic [3:0] KEY_DOWN2  = 4'd6;
    localparam logic [3:0] KEY_LEFT2  = 4'd7;
    localparam logic [3:0] KEY_RIGHT2 = 4'd8;
    localparam logic [3:0] KEY_FIRE2  = 4'd9;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_map_t;

    // Keypad Enter (E0 5A) and keypad digits (plain 75/72/6B/74) fall through
    function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = 4'd0;
        if (ext) begin
            case (code)
                SC_UP:    m.idx = KEY_UP2;
                SC_DOWN:  m.idx = KEY_DOWN2;
                SC_LEFT:  m.idx = KEY_LEFT2;
                SC_RIGHT: m.idx = KEY_RIGHT2;
                default:  m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                SC_W:     m.idx = KEY_UP1;
                SC_S:     m.idx = KEY_DOWN1;
                SC_A:     m.idx = KEY_LEFT1;
                SC_D:     m.idx = KEY_RIGHT1;
                SC_SPACE: m.idx = KEY_FIRE1;
                SC_ENTER: m.idx = KEY_FIRE2;
                default:  m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_decoder_if
// Desc   : PS/2 line inputs plus decoded key levels and byte status outputs.
// Rev    : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic       up1;
    logic       down1;
    logic       left1;
    logic       right1;
    logic       fire1;
    logic       up2;
    logic       down2;
    logic       left2;
    logic       right2;
    logic       fire2;
    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    // Keyboard/host side
    modport master (
        output ps2_clk, ps2_data,
        input  up1, down1, left1, right1, fire1,
        input  up2, down2, left2, right2, fire2,
        input  byte_valid, rx_byte, frame_err
    );

    // Decoder side
    modport slave (
        input  ps2_clk, ps2_data,
        output up1, down1, left1, right1, fire1,
        output up2, down2, left2, right2, fire2,
        output byte_valid, rx_byte, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module : ps2_rx
// Desc   : PS/2 frame receiver: synchronizers, clock glitch filter, 11-bit
//          frame shifter with parity/stop checking and inactivity timeout.
// Rev    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import tankwar_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  wire logic       clk,
    input  wire logic       clrn,
    input  wire logic       i_ps2_clk,
    input  wire logic       i_ps2_data,
    output logic            o_byte_valid,
    output logic [7:0]      o_rx_byte,
    output logic            o_frame_err
);

    localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [FLT_W-1:0] c_FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]       c_LAST_BIT = 4'd10;

    logic             r_clk_s1, r_clk_s2;
    logic             r_dat_s1, r_dat_s2;
    logic             r_filt_clk, r_filt_d;
    logic [FLT_W-1:0] r_flt_cnt;
    logic             w_fall;

    rx_state_e        r_state, w_state_nxt;
    logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [9:0]       r_shift, w_shift_nxt;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nxt;
    logic             w_ok, w_err;
    logic             r_byte_valid, r_frame_err;
    logic [7:0]       r_rx_byte;

    // Bus idles high, so the front end resets to 1 to avoid a false edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_filt_clk <= 1'b1;
            r_filt_d   <= 1'b1;
            r_flt_cnt  <= '0;
        end else begin
            r_clk_s1 <= i_ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= i_ps2_data;
            r_dat_s2 <= r_dat_s1;
            r_filt_d <= r_filt_clk;
            if (r_clk_s2 == r_filt_clk) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FLT_LAST) begin
                r_filt_clk <= r_clk_s2;
                r_flt_cnt  <= '0;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_d & ~r_filt_clk;

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_to_cnt_nxt  = r_to_cnt;
        w_ok          = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_bit_cnt_nxt = '0;
                w_to_cnt_nxt  = '0;
                if (w_fall && !r_dat_s2) begin
                    w_state_nxt   = RX_SHIFT;
                    w_bit_cnt_nxt = 4'd1;
                end
            end
            RX_SHIFT: begin
                if (w_fall) begin
                    // After ten shifts: [7:0] data, [8] parity, [9] stop
                    w_to_cnt_nxt = '0;
                    w_shift_nxt  = {r_dat_s2, r_shift[9:1]};
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_nxt   = RX_CHECK;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt   = RX_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_to_cnt_nxt  = '0;
                    w_err         = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            RX_CHECK: begin
                w_state_nxt = RX_IDLE;
                if ((^r_shift[8:0]) && r_shift[9]) begin
                    w_ok = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= RX_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_to_cnt     <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_byte    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_to_cnt     <= w_to_cnt_nxt;
            r_byte_valid <= w_ok;
            r_frame_err  <= w_err;
            if (w_ok) begin
                r_rx_byte <= r_shift[7:0];
            end
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_rx_byte    = r_rx_byte;
    assign o_frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module : ps2_key_decoder
// Desc   : PS/2 keyboard to two-player key levels; make/break decoder on top
//          of the ps2_rx frame receiver.
// Rev    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
    import tankwar_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  wire logic         clk,
    input  wire logic         clrn,
    ps2_key_decoder_if.slave  ps2
);

    logic                w_byte_valid;
    logic [7:0]          w_rx_byte;
    logic                w_frame_err;
    key_map_t            w_map;

    logic                r_ext;
    logic                r_brk;
    logic [NUM_KEYS-1:0] r_keys;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_rx (
        .clk          (clk),
        .clrn         (clrn),
        .i_ps2_clk    (ps2.ps2_clk),
        .i_ps2_data   (ps2.ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_rx_byte    (w_rx_byte),
        .o_frame_err  (w_frame_err)
    );

    assign w_map = map_key(r_ext, w_rx_byte);

    // Only good bytes reach the decoder; frame errors leave it untouched
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_keys <= '0;
        end else if (w_byte_valid) begin
            case (w_rx_byte)
                SC_E0: begin
                    r_ext <= 1'b1;
                end
                SC_F0: begin
                    r_brk <= 1'b1;
                end
                SC_ACK, SC_BAT_OK, SC_ECHO, SC_RESEND: begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
                SC_OVR_00, SC_OVR_FF: begin
                    r_ext  <= 1'b0;
                    r_brk  <= 1'b0;
                    r_keys <= '0;
                end
                default: begin
                    if (w_map.hit) begin
                        r_keys[w_map.idx] <= ~r_brk;
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            endcase
        end
    end

    assign ps2.up1        = r_keys[KEY_UP1];
    assign ps2.down1      = r_keys[KEY_DOWN1];
    assign ps2.left1      = r_keys[KEY_LEFT1];
    assign ps2.right1     = r_keys[KEY_RIGHT1];
    assign ps2.fire1      = r_keys[KEY_FIRE1];
    assign ps2.up2        = r_keys[KEY_UP2];
    assign ps2.down2      = r_keys[KEY_DOWN2];
    assign ps2.left2      = r_keys[KEY_LEFT2];
    assign ps2.right2     = r_keys[KEY_RIGHT2];
    assign ps2.fire2      = r_keys[KEY_FIRE2];
    assign ps2.byte_valid = w_byte_valid;
    assign ps2.rx_byte    = w_rx_byte;
    assign ps2.frame_err  = w_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_ps2_key_decoder
// Desc   : Scoreboard bench: frames are sent at a 40 us bit period, expected
//          byte/error events and key vectors are queued and checked by a monitor.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

    // 1 MHz system clock: 20 cycles per PS/2 half-bit keeps the run short
    localparam time CLK_HALF = 500ns;
    localparam int  HALF_BIT = 20;

    localparam logic [9:0] K_UP1 = 10'h001, K_DOWN1 = 10'h002, K_LEFT1 = 10'h004;
    localparam logic [9:0] K_RIGHT1 = 10'h008, K_FIRE1 = 10'h010, K_UP2 = 10'h020;
    localparam logic [9:0] K_FIRE2 = 10'h200;

    typedef struct {
        bit         is_err;
        logic [7:0] rx;
        logic [9:0] kb;
        logic [9:0] ka;
    } exp_t;

    logic clk;
    logic clrn;
    ps2_key_decoder_if ps2();

    ps2_key_decoder #(.FILTER_LEN(4), .TIMEOUT(50000)) dut (
        .clk  (clk),
        .clrn (clrn),
        .ps2  (ps2)
    );

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [9:0] cur_keys = '0;

    initial clk = 1'b0;
    always #(CLK_HALF) clk = ~clk;

    function automatic logic [9:0] keys_now();
        return {ps2.fire2, ps2.right2, ps2.left2, ps2.down2, ps2.up2,
                ps2.fire1, ps2.right1, ps2.left1, ps2.down1, ps2.up1};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every status pulse must match the head of the scoreboard
    always begin
        @(negedge clk);
        if (clrn === 1'b1 && (ps2.byte_valid === 1'b1 || ps2.frame_err === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {ps2.byte_valid, ps2.frame_err, ps2.rx_byte}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", {30'd0, ps2.byte_valid, ps2.frame_err}, {30'd0, !e.is_err, e.is_err});
                check("rx_byte", {24'd0, ps2.rx_byte}, {24'd0, e.rx});
                check("keys_at_pulse", {22'd0, keys_now()}, {22'd0, e.kb});
                @(negedge clk);
                check("keys_after", {22'd0, keys_now()}, {22'd0, e.ka});
                check("pulse_width", {30'd0, ps2.byte_valid, ps2.frame_err}, 32'd0);
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drives nbits of a frame; bad_par flips the parity bit
    task automatic drive_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2.ps2_data = bits[i];
            wait_cycles(HALF_BIT);
            ps2.ps2_clk = 1'b0;
            wait_cycles(HALF_BIT);
            ps2.ps2_clk = 1'b1;
        end
        ps2.ps2_data = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        wait_cycles(4);
    endtask

    task automatic send(input logic [7:0] b, input logic [9:0] ka);
        exp_t e;
        e.is_err = 1'b0; e.rx = b; e.kb = cur_keys; e.ka = ka;
        sb.push_back(e);
        cur_keys = ka;
        drive_frame(b, 1'b0, 11);
        wait_drain(200);
    endtask

    task automatic send_err(input logic [7:0] b, input int nbits, input logic [7:0] held, input int budget);
        exp_t e;
        e.is_err = 1'b1; e.rx = held; e.kb = cur_keys; e.ka = cur_keys;
        sb.push_back(e);
        drive_frame(b, 1'b1, nbits);
        wait_drain(budget);
    endtask

    initial begin
        ps2.ps2_clk  = 1'b1;
        ps2.ps2_data = 1'b1;
        clrn = 1'b0;
        wait_cycles(5);
        @(negedge clk);
        check("reset_outputs", {13'd0, ps2.byte_valid, ps2.frame_err, ps2.rx_byte, keys_now()}, 32'd0);
        clrn = 1'b1;
        wait_cycles(20);

        // Make and break of W
        send(8'h1D, K_UP1);
        send(8'hF0, K_UP1);
        send(8'h1D, 10'h000);
        // Extended Up alongside W
        send(8'hE0, 10'h000);
        send(8'h75, K_UP2);
        send(8'h1D, K_UP2 | K_UP1);
        send(8'hE0, K_UP2 | K_UP1);
        send(8'hF0, K_UP2 | K_UP1);
        send(8'h75, K_UP1);
        // Main Enter, keypad Enter, keypad 8
        send(8'h5A, K_UP1 | K_FIRE2);
        send(8'hE0, K_UP1 | K_FIRE2);
        send(8'h5A, K_UP1 | K_FIRE2);
        send(8'h75, K_UP1 | K_FIRE2);
        send(8'hF0, K_UP1 | K_FIRE2);
        send(8'h1D, K_FIRE2);
        send(8'hF0, K_FIRE2);
        send(8'h5A, 10'h000);
        // Parity error keeps rx_byte and keys
        send_err(8'h1D, 11, 8'h5A, 200);
        send(8'h1C, K_LEFT1);
        // Abandoned partial frame then a full one
        send_err(8'h23, 4, 8'h1C, 60000);
        send(8'h23, K_LEFT1 | K_RIGHT1);
        // ACK drops the pending E0 so 74 is an unmapped plain code
        send(8'hE0, K_LEFT1 | K_RIGHT1);
        send(8'hFA, K_LEFT1 | K_RIGHT1);
        send(8'h74, K_LEFT1 | K_RIGHT1);
        // Overrun clears everything
        send(8'h29, K_LEFT1 | K_RIGHT1 | K_FIRE1);
        send(8'h1B, K_LEFT1 | K_RIGHT1 | K_FIRE1 | K_DOWN1);
        send(8'hFF, 10'h000);
        // Reset in the middle of a frame
        send(8'h29, K_FIRE1);
        drive_frame(8'h1D, 1'b0, 5);
        wait_cycles(3);
        clrn = 1'b0;
        wait_cycles(3);
        @(negedge clk);
        check("midframe_reset_outputs", {13'd0, ps2.byte_valid, ps2.frame_err, ps2.rx_byte, keys_now()}, 32'd0);
        cur_keys = '0;
        clrn = 1'b1;
        wait_cycles(50);
        send(8'h1C, K_LEFT1);
        wait_cycles(100);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
